// File: rtl/titan_lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// titan_lsu_ctrl_if
// Data-side Wishbone classic bus between the Titan load/store sequencer
// (master) and the data memory/peripheral fabric (slave).
//
// Signals (named from the master's point of view):
//   wbm_adr_o  [31:0]  word-aligned byte address
//   wbm_dat_o  [31:0]  write data, lanes replicated for sub-word stores
//   wbm_sel_o  [3:0]   byte-lane enables
//   wbm_we_o           write enable
//   wbm_cyc_o          bus cycle in progress
//   wbm_stb_o          strobe
//   wbm_dat_i  [31:0]  read data from slave
//   wbm_ack_i          normal termination
//   wbm_err_i          error termination
// ---------------------------------------------------------------------------
interface titan_lsu_ctrl_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/titan_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// titan_lsu_ctrl
// Load/store sequencer between the Titan MEM stage and the data Wishbone bus.
// Runs one Wishbone classic read or write per memory instruction, returns the
// cyc/ack handshake the MEM stage turns into its stall, delivers lane-aligned
// and sign/zero-extended load data, and flags misalignment, bus errors and
// unresponsive slaves.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   lsu_addr_i  [31:0]      byte address
//   lsu_wdat_i  [31:0]      store data, right-justified
//   lsu_mread_i/mwrite_i    load / store request (level)
//   lsu_mbyte_i/mhw_i/mword_i/munsigned_i   size and extension flags
//   lsu_hold_i              pipeline held by another stall source
//   lsu_kill_i              MEM stage flush
//   lsu_cyc_o               access in progress
//   lsu_ack_o               access complete, data/fault valid
//   lsu_rdat_o  [31:0]      aligned load data (0 for stores and faults)
//   lsu_misaligned_o        combinational misalignment flag
//   lsu_fault_o             bus error or timeout, valid with lsu_ack_o
//   wbm                     Wishbone master port (all outputs registered)
// ---------------------------------------------------------------------------
module titan_lsu_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [31:0]              lsu_addr_i,
  input  logic [31:0]              lsu_wdat_i,
  input  logic                     lsu_mread_i,
  input  logic                     lsu_mwrite_i,
  input  logic                     lsu_mbyte_i,
  input  logic                     lsu_mhw_i,
  input  logic                     lsu_mword_i,
  input  logic                     lsu_munsigned_i,
  input  logic                     lsu_hold_i,
  input  logic                     lsu_kill_i,
  output logic                     lsu_cyc_o,
  output logic                     lsu_ack_o,
  output logic [31:0]              lsu_rdat_o,
  output logic                     lsu_misaligned_o,
  output logic                     lsu_fault_o,
  titan_lsu_ctrl_if.master         wbm
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t          state_r, state_nxt_s;

  logic [31:0]     adr_r, dat_r, rdat_r;
  logic [3:0]      sel_r;
  logic            we_r, cyc_r, stb_r, fault_r;
  logic [CW-1:0]   cnt_r;

  // access attributes captured when the bus cycle starts
  logic [1:0]      lane_r;
  logic            byte_r, hw_r, uns_r, store_r;

  logic            req_s, is_byte_s, is_hw_s, mis_s;
  logic            timeout_s, bus_err_s, bus_end_s;
  logic            start_s, term_s, capture_s, cyc_s;

  // Byte-lane enables for a sub-word or word access.
  function automatic logic [3:0] wb_sel(input logic b, input logic h, input logic [1:0] a);
    logic [3:0] s;
    if (b) begin
      s = 4'b0001 << a;
    end else if (h) begin
      s = a[1] ? 4'b1100 : 4'b0011;
    end else begin
      s = 4'b1111;
    end
    return s;
  endfunction

  // Store data replicated onto every lane the slave might pick it up from.
  function automatic logic [31:0] wb_wdat(input logic b, input logic h, input logic [31:0] d);
    logic [31:0] r;
    if (b) begin
      r = {4{d[7:0]}};
    end else if (h) begin
      r = {2{d[15:0]}};
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Select the addressed lane of the read word and extend it to 32 bits.
  function automatic logic [31:0] load_align(input logic [31:0] d, input logic [1:0] a,
                                             input logic b, input logic h, input logic u);
    logic [7:0]  bv;
    logic [15:0] hv;
    logic [31:0] r;
    case (a)
      2'd0:    bv = d[7:0];
      2'd1:    bv = d[15:8];
      2'd2:    bv = d[23:16];
      2'd3:    bv = d[31:24];
      default: bv = 8'd0;
    endcase
    hv = a[1] ? d[31:16] : d[15:0];
    if (b) begin
      r = u ? {24'd0, bv} : {{24{bv[7]}}, bv};
    end else if (h) begin
      r = u ? {16'd0, hv} : {{16{hv[15]}}, hv};
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Request decode: store wins over load, no size flag means word.
  assign req_s     = lsu_mread_i | lsu_mwrite_i;
  assign is_byte_s = lsu_mbyte_i;
  assign is_hw_s   = ~lsu_mbyte_i & lsu_mhw_i;
  assign mis_s     = is_byte_s ? 1'b0 : (is_hw_s ? lsu_addr_i[0] : (lsu_addr_i[1:0] != 2'd0));

  // Bus termination; an error (or timeout) takes precedence over ack.
  assign timeout_s = (cnt_r == CW'(TIMEOUT - 1));
  assign bus_err_s = wbm.wbm_err_i | timeout_s;
  assign bus_end_s = wbm.wbm_ack_i | bus_err_s;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_nxt_s = state_r;
    cyc_s       = 1'b0;
    start_s     = 1'b0;
    term_s      = 1'b0;
    capture_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cyc_s = req_s & ~mis_s;
        if (req_s & ~mis_s & ~lsu_kill_i) begin
          start_s     = 1'b1;
          state_nxt_s = ST_BUS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        cyc_s = 1'b1;
        if (bus_end_s) begin
          // a flush landing on the terminating cycle simply drops the result
          term_s = 1'b1;
          if (lsu_kill_i) begin
            state_nxt_s = ST_IDLE;
          end else begin
            capture_s   = 1'b1;
            state_nxt_s = ST_DONE;
          end
        end else if (lsu_kill_i) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_BUS;
        end
      end
      ST_DONE: begin
        cyc_s = 1'b1;
        if (~lsu_hold_i | lsu_kill_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DRAIN: begin
        // the killed cycle must still finish on the bus; a new request waits
        cyc_s = req_s;
        if (bus_end_s) begin
          term_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Wishbone master registers, timeout counter and load result.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      adr_r   <= 32'd0;
      dat_r   <= 32'd0;
      sel_r   <= 4'd0;
      we_r    <= 1'b0;
      cyc_r   <= 1'b0;
      stb_r   <= 1'b0;
      cnt_r   <= '0;
      rdat_r  <= 32'd0;
      fault_r <= 1'b0;
      lane_r  <= 2'd0;
      byte_r  <= 1'b0;
      hw_r    <= 1'b0;
      uns_r   <= 1'b0;
      store_r <= 1'b0;
    end else if (start_s) begin
      adr_r   <= {lsu_addr_i[31:2], 2'b00};
      dat_r   <= wb_wdat(is_byte_s, is_hw_s, lsu_wdat_i);
      sel_r   <= wb_sel(is_byte_s, is_hw_s, lsu_addr_i[1:0]);
      we_r    <= lsu_mwrite_i;
      cyc_r   <= 1'b1;
      stb_r   <= 1'b1;
      cnt_r   <= '0;
      lane_r  <= lsu_addr_i[1:0];
      byte_r  <= is_byte_s;
      hw_r    <= is_hw_s;
      uns_r   <= lsu_munsigned_i;
      store_r <= lsu_mwrite_i;
    end else if (term_s) begin
      cyc_r <= 1'b0;
      stb_r <= 1'b0;
      cnt_r <= '0;
      if (capture_s) begin
        fault_r <= bus_err_s;
        rdat_r  <= (bus_err_s | store_r) ? 32'd0
                 : load_align(wbm.wbm_dat_i, lane_r, byte_r, hw_r, uns_r);
      end
    end else if ((state_r == ST_BUS) || (state_r == ST_DRAIN)) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign lsu_cyc_o        = cyc_s;
  assign lsu_ack_o        = (state_r == ST_DONE);
  assign lsu_rdat_o       = rdat_r;
  assign lsu_fault_o      = fault_r;
  assign lsu_misaligned_o = req_s & mis_s;

  assign wbm.wbm_adr_o = adr_r;
  assign wbm.wbm_dat_o = dat_r;
  assign wbm.wbm_sel_o = sel_r;
  assign wbm.wbm_we_o  = we_r;
  assign wbm.wbm_cyc_o = cyc_r;
  assign wbm.wbm_stb_o = stb_r;

endmodule

// File: tb/tb_titan_lsu_ctrl.sv
// Directed testbench for titan_lsu_ctrl with hand-computed expectations.
module tb_titan_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lsu_addr, lsu_wdat, lsu_rdat;
  logic        lsu_mread, lsu_mwrite, lsu_mbyte, lsu_mhw, lsu_mword, lsu_munsigned;
  logic        lsu_hold, lsu_kill;
  logic        lsu_cyc, lsu_ack, lsu_misaligned, lsu_fault;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_cnt, ack_cnt, wb_seen, n;

  titan_lsu_ctrl_if wbm ();

  titan_lsu_ctrl #(.TIMEOUT(16)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .lsu_addr_i      (lsu_addr),
    .lsu_wdat_i      (lsu_wdat),
    .lsu_mread_i     (lsu_mread),
    .lsu_mwrite_i    (lsu_mwrite),
    .lsu_mbyte_i     (lsu_mbyte),
    .lsu_mhw_i       (lsu_mhw),
    .lsu_mword_i     (lsu_mword),
    .lsu_munsigned_i (lsu_munsigned),
    .lsu_hold_i      (lsu_hold),
    .lsu_kill_i      (lsu_kill),
    .lsu_cyc_o       (lsu_cyc),
    .lsu_ack_o       (lsu_ack),
    .lsu_rdat_o      (lsu_rdat),
    .lsu_misaligned_o(lsu_misaligned),
    .lsu_fault_o     (lsu_fault),
    .wbm             (wbm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move 2 time units past the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Let combinational outputs settle and accumulate per-cycle observations.
  task automatic settle();
    #1;
    cyc_cnt += int'(lsu_cyc);
    ack_cnt += int'(lsu_ack);
    wb_seen += int'(wbm.wbm_cyc_o);
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic b, input logic h,
                         input logic w, input logic u, input logic [31:0] a,
                         input logic [31:0] wd);
    lsu_mread = rd; lsu_mwrite = wr; lsu_mbyte = b; lsu_mhw = h;
    lsu_mword = w; lsu_munsigned = u; lsu_addr = a; lsu_wdat = wd;
  endtask

  task automatic clr_req();
    set_req(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic zero_counts();
    cyc_cnt = 0; ack_cnt = 0; wb_seen = 0;
  endtask

  initial begin
    rst = 1'b1;
    clr_req();
    lsu_hold = 1'b0; lsu_kill = 1'b0;
    wbm.wbm_dat_i = 32'd0; wbm.wbm_ack_i = 1'b0; wbm.wbm_err_i = 1'b0;
    zero_counts();

    // Reset state
    repeat (2) tick();
    settle();
    check("rst_ack",   32'(lsu_ack), 32'd0);
    check("rst_wbcyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("rst_sel",   32'(wbm.wbm_sel_o), 32'd0);
    check("rst_rdat",  lsu_rdat, 32'd0);
    rst = 1'b0;

    // LB signed, 0x1003, one wait state, data 0x80AABBCC
    tick();
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1003, 32'd0);
    zero_counts();
    settle();
    check("lb_idle_cyc", 32'(lsu_cyc), 32'd1);
    tick(); settle();
    check("lb_stb", 32'(wbm.wbm_stb_o), 32'd1);
    check("lb_sel", 32'(wbm.wbm_sel_o), 32'h8);
    check("lb_adr", wbm.wbm_adr_o, 32'h0000_1000);
    check("lb_we",  32'(wbm.wbm_we_o), 32'd0);
    tick();
    wbm.wbm_dat_i = 32'h80AA_BBCC; wbm.wbm_ack_i = 1'b1;
    settle();
    check("lb_wait_ack", 32'(lsu_ack), 32'd0);
    tick();
    wbm.wbm_ack_i = 1'b0; clr_req();
    settle();
    check("lb_ack",   32'(lsu_ack), 32'd1);
    check("lb_rdat",  lsu_rdat, 32'hFFFF_FF80);
    check("lb_fault", 32'(lsu_fault), 32'd0);
    check("lb_wbcyc_drop", 32'(wbm.wbm_cyc_o), 32'd0);
    tick(); settle();
    check("lb_ack_after", 32'(lsu_ack), 32'd0);
    check("lb_cyc_cycles", 32'(cyc_cnt), 32'd4);
    check("lb_ack_cycles", 32'(ack_cnt), 32'd1);

    // LHU, 0x2002, zero wait, data 0x80011234
    set_req(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_2002, 32'd0);
    tick(); settle();
    check("lhu_sel", 32'(wbm.wbm_sel_o), 32'hC);
    wbm.wbm_dat_i = 32'h8001_1234; wbm.wbm_ack_i = 1'b1;
    tick();
    wbm.wbm_ack_i = 1'b0; clr_req();
    settle();
    check("lhu_ack",  32'(lsu_ack), 32'd1);
    check("lhu_rdat", lsu_rdat, 32'h0000_8001);

    // SH, 0x2002, wdat 0xDEAD1234
    tick();
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2002, 32'hDEAD_1234);
    tick(); settle();
    check("sh_we",  32'(wbm.wbm_we_o), 32'd1);
    check("sh_sel", 32'(wbm.wbm_sel_o), 32'hC);
    check("sh_dat", wbm.wbm_dat_o, 32'h1234_1234);
    check("sh_adr", wbm.wbm_adr_o, 32'h0000_2000);
    wbm.wbm_dat_i = 32'h5555_AAAA; wbm.wbm_ack_i = 1'b1;
    tick();
    wbm.wbm_ack_i = 1'b0; clr_req();
    settle();
    check("sh_ack",  32'(lsu_ack), 32'd1);
    check("sh_rdat", lsu_rdat, 32'd0);

    // Misaligned LW, 0x3001
    tick();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_3001, 32'd0);
    zero_counts();
    settle();
    check("mis_flag", 32'(lsu_misaligned), 32'd1);
    check("mis_cyc",  32'(lsu_cyc), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
    end
    check("mis_wbcyc_never", 32'(wb_seen), 32'd0);
    clr_req();

    // Silent slave: fault with ack 16 cycles after BUS entry
    tick();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_4000, 32'd0);
    tick(); settle();
    check("to_bus", 32'(wbm.wbm_cyc_o), 32'd1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick(); settle();
      n++;
      if (lsu_ack) break;
    end
    check("to_latency", 32'(n), 32'd16);
    check("to_fault",   32'(lsu_fault), 32'd1);
    check("to_rdat",    lsu_rdat, 32'd0);
    check("to_wbcyc",   32'(wbm.wbm_cyc_o), 32'd0);
    clr_req();

    // Ack and err together: err wins
    tick();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_5000, 32'd0);
    tick();
    wbm.wbm_dat_i = 32'h1234_5678; wbm.wbm_ack_i = 1'b1; wbm.wbm_err_i = 1'b1;
    tick();
    wbm.wbm_ack_i = 1'b0; wbm.wbm_err_i = 1'b0; clr_req();
    settle();
    check("err_ack",   32'(lsu_ack), 32'd1);
    check("err_fault", 32'(lsu_fault), 32'd1);
    check("err_rdat",  lsu_rdat, 32'd0);

    // Kill during BUS: drain, no ack, cyc drops on the later ack
    tick();
    set_req(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_6000, 32'd0);
    zero_counts();
    tick();
    lsu_kill = 1'b1;
    tick();
    lsu_kill = 1'b0; clr_req();
    settle();
    check("kill_drain_wbcyc", 32'(wbm.wbm_cyc_o), 32'd1);
    check("kill_drain_cyc",   32'(lsu_cyc), 32'd0);
    tick();
    wbm.wbm_dat_i = 32'hFFFF_FFFF; wbm.wbm_ack_i = 1'b1;
    settle();
    check("kill_drain_hold", 32'(wbm.wbm_cyc_o), 32'd1);
    tick();
    wbm.wbm_ack_i = 1'b0;
    settle();
    check("kill_wbcyc_drop", 32'(wbm.wbm_cyc_o), 32'd0);
    check("kill_no_ack",     32'(ack_cnt), 32'd0);

    // Hold for 3 cycles in DONE: LBU 0x7001 -> 0xA5, ack held 4 cycles
    tick();
    set_req(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_7001, 32'd0);
    tick();
    wbm.wbm_dat_i = 32'h0000_A500; wbm.wbm_ack_i = 1'b1; lsu_hold = 1'b1;
    zero_counts();
    for (int i = 0; i < 4; i++) begin
      tick();
      wbm.wbm_ack_i = 1'b0;
      if (i == 3) lsu_hold = 1'b0;
      settle();
      check("hold_rdat", lsu_rdat, 32'h0000_00A5);
    end
    tick();
    clr_req();
    settle();
    check("hold_ack_cycles", 32'(ack_cnt), 32'd4);
    check("hold_exit",       32'(lsu_ack), 32'd0);

    // Reset mid-BUS clears everything immediately
    tick();
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_8004, 32'hCAFE_F00D);
    tick(); settle();
    check("rstbus_pre", 32'(wbm.wbm_cyc_o), 32'd1);
    clr_req();
    rst = 1'b1;
    #1;
    check("rstbus_wbcyc", 32'(wbm.wbm_cyc_o), 32'd0);
    check("rstbus_stb",   32'(wbm.wbm_stb_o), 32'd0);
    check("rstbus_adr",   wbm.wbm_adr_o, 32'd0);
    check("rstbus_dat",   wbm.wbm_dat_o, 32'd0);
    check("rstbus_we",    32'(wbm.wbm_we_o), 32'd0);
    check("rstbus_cyc",   32'(lsu_cyc), 32'd0);
    check("rstbus_ack",   32'(lsu_ack), 32'd0);
    #3;
    rst = 1'b0;
    tick(); settle();
    check("rstbus_idle", 32'(wbm.wbm_cyc_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
